// File: rtl/sram_responder.sv
// Device-side model of a 128K x 8 asynchronous SRAM, sampled on the system clock.
// Writes commit to on-chip memory; reads drive the shared dq bus after RD_LAT edges.
module sram_responder #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8,
    parameter int MEM_AW = 17,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_dq,
    input  logic              ram_we_,
    input  logic              ram_oe_,
    input  logic              ram_cs1_,
    input  logic              ram_cs2,
    output logic              rd_valid,
    output logic              wr_strobe,
    output logic              err
);

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DRIVE, WR} state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [ADDR_W-1:0] rd_addr_reg;
    logic [ADDR_W-1:0] wa_reg;
    logic [DATA_W-1:0] wd_reg;
    logic [DATA_W-1:0] rd_data_reg;
    logic              dq_en_reg;
    logic              wr_strobe_reg;
    logic              err_reg;

    logic [DATA_W-1:0] mem [0:(1<<MEM_AW)-1];

    logic sel;
    logic rd_qual;
    logic wr_qual;
    logic commit;

    assign sel     = !ram_cs1_ && ram_cs2;
    assign wr_qual = sel && !ram_we_;
    assign rd_qual = sel && ram_we_ && !ram_oe_;
    assign commit  = (state_reg == WR) && !wr_qual;

    assign ram_dq    = dq_en_reg ? rd_data_reg : {DATA_W{1'bz}};
    assign rd_valid  = dq_en_reg;
    assign wr_strobe = wr_strobe_reg;
    assign err       = err_reg;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            rd_addr_reg   <= '0;
            wa_reg        <= '0;
            wd_reg        <= '0;
            dq_en_reg     <= 1'b0;
            wr_strobe_reg <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            wr_strobe_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (wr_qual) begin
                        state_reg <= WR;
                        wa_reg    <= ram_addr;
                        wd_reg    <= ram_dq;
                    end else if (rd_qual) begin
                        state_reg   <= (RD_LAT == 1) ? RD_DRIVE : RD_WAIT;
                        rd_addr_reg <= ram_addr;
                        cnt_reg     <= CNT_LOAD;
                    end
                end
                RD_WAIT, RD_DRIVE: begin
                    if (!rd_qual) begin
                        dq_en_reg <= 1'b0;
                        if (wr_qual) begin
                            state_reg <= WR;
                            wa_reg    <= ram_addr;
                            wd_reg    <= ram_dq;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else if (ram_addr != rd_addr_reg) begin
                        // tAA restarts from the new address
                        dq_en_reg   <= 1'b0;
                        state_reg   <= (RD_LAT == 1) ? RD_DRIVE : RD_WAIT;
                        rd_addr_reg <= ram_addr;
                        cnt_reg     <= CNT_LOAD;
                    end else if (state_reg == RD_WAIT) begin
                        if (cnt_reg <= CNT_W'(1)) begin
                            cnt_reg   <= '0;
                            state_reg <= RD_DRIVE;
                        end else begin
                            cnt_reg <= cnt_reg - CNT_W'(1);
                        end
                    end else begin
                        // read register holds mem[rd_addr_reg] by the same edge
                        dq_en_reg <= 1'b1;
                    end
                end
                WR: begin
                    if (wr_qual) begin
                        if (ram_addr != wa_reg) begin
                            err_reg <= 1'b1;
                        end
                        wa_reg <= ram_addr;
                        wd_reg <= ram_dq;
                    end else begin
                        wr_strobe_reg <= 1'b1;
                        if (rd_qual) begin
                            state_reg   <= (RD_LAT == 1) ? RD_DRIVE : RD_WAIT;
                            rd_addr_reg <= ram_addr;
                            cnt_reg     <= CNT_LOAD;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Unreset storage with a registered read port so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[wa_reg[MEM_AW-1:0]] <= wd_reg;
        end
        rd_data_reg <= mem[rd_addr_reg[MEM_AW-1:0]];
    end

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboarded bench for sram_responder: stimulus pushes expected read data and
// write commits; a negedge monitor pops and compares as the DUT presents them.
module tb_sram_responder;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 8;
    localparam int MEM_AW = 4;
    localparam int RD_LAT = 2;

    logic              clk = 1'b0;
    logic              reset_;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we_;
    logic              ram_oe_;
    logic              ram_cs1_;
    logic              ram_cs2;
    logic [DATA_W-1:0] tb_dq;
    logic              tb_dq_en;
    wire  [DATA_W-1:0] ram_dq;
    logic              rd_valid;
    logic              wr_strobe;
    logic              err;

    assign ram_dq = tb_dq_en ? tb_dq : {DATA_W{1'bz}};

    always #5 clk = ~clk;

    sram_responder #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .MEM_AW(MEM_AW),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk      (clk),
        .reset_   (reset_),
        .ram_addr (ram_addr),
        .ram_dq   (ram_dq),
        .ram_we_  (ram_we_),
        .ram_oe_  (ram_oe_),
        .ram_cs1_ (ram_cs1_),
        .ram_cs2  (ram_cs2),
        .rd_valid (rd_valid),
        .wr_strobe(wr_strobe),
        .err      (err)
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [7:0]  exp_rd_q[$];
    int          exp_wr = 0;
    logic [7:0]  model [0:15];
    logic        rv_prev = 1'b0;
    logic        ws_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares read data on each rd_valid rise and accounts for write commits.
    always @(negedge clk) begin
        if (rd_valid && !rv_prev) begin
            check("rd_expected", exp_rd_q.size() > 0, 1);
            if (exp_rd_q.size() > 0) begin
                logic [7:0] e;
                e = exp_rd_q.pop_front();
                check("rd_data", ram_dq, e);
                $display("read  data=0x%02h expected=0x%02h", ram_dq, e);
            end
        end
        if (wr_strobe) begin
            check("wr_strobe_width", ws_prev, 0);
            check("wr_expected", exp_wr > 0, 1);
            if (exp_wr > 0) exp_wr--;
            $display("write commit strobe");
        end
        if (tb_dq_en) check("no_drive_during_write", rd_valid, 0);
        rv_prev = rd_valid;
        ws_prev = wr_strobe;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        ram_cs1_ = 1'b1;
        ram_cs2  = 1'b0;
        ram_we_  = 1'b1;
        ram_oe_  = 1'b1;
        tb_dq_en = 1'b0;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [7:0] d, input int n);
        ram_cs1_ = 1'b0;
        ram_cs2  = 1'b1;
        ram_addr = a;
        tb_dq    = d;
        tb_dq_en = 1'b1;
        ram_we_  = 1'b0;
        ram_oe_  = 1'b1;
        repeat (n) tick();
        set_idle();
        exp_wr++;
        model[a[3:0]] = d;
        tick();
        check("wr_strobe_pulse", wr_strobe, 1);
    endtask

    // Qualifies a read at E0 and checks rd_valid is low through E0+1 and high after E0+2.
    task automatic read_start(input logic [ADDR_W-1:0] a);
        ram_cs1_ = 1'b0;
        ram_cs2  = 1'b1;
        ram_we_  = 1'b1;
        ram_oe_  = 1'b0;
        ram_addr = a;
        exp_rd_q.push_back(model[a[3:0]]);
        tick();
        check("rd_lat_e0", rd_valid, 0);
        tick();
        check("rd_lat_e1", rd_valid, 0);
        tick();
        check("rd_lat_e2", rd_valid, 1);
    endtask

    task automatic read_end();
        ram_oe_ = 1'b1;
        tick();
        check("rd_turnoff", rd_valid, 0);
        set_idle();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        reset_   = 1'b0;
        ram_addr = '0;
        tb_dq    = '0;
        set_idle();
        repeat (2) tick();
        check("rst_rd_valid", rd_valid, 0);
        check("rst_wr_strobe", wr_strobe, 0);
        check("rst_err", err, 0);
        reset_ = 1'b1;
        tick();

        // write then read with the programmed latency
        do_write(17'd100, 8'hA5, 2);
        read_start(17'd100);
        read_end();

        // address change while driving
        do_write(17'd5, 8'h11, 1);
        do_write(17'd6, 8'h22, 1);
        read_start(17'd5);
        ram_addr = 17'd6;
        exp_rd_q.push_back(model[6]);
        tick();
        check("addr_chg_drop", rd_valid, 0);
        tick();
        check("addr_chg_wait", rd_valid, 0);
        tick();
        check("addr_chg_valid", rd_valid, 1);
        read_end();

        // we_ overrides oe_
        ram_cs1_ = 1'b0;
        ram_cs2  = 1'b1;
        ram_addr = 17'd7;
        ram_we_  = 1'b0;
        ram_oe_  = 1'b0;
        tb_dq    = 8'h3C;
        tb_dq_en = 1'b1;
        repeat (2) begin
            tick();
            check("we_prio_no_drive", rd_valid, 0);
        end
        set_idle();
        exp_wr++;
        model[7] = 8'h3C;
        tick();
        check("we_prio_commit", wr_strobe, 1);
        read_start(17'd7);
        read_end();

        // aliasing of upper address bits
        do_write(17'h13, 8'h5A, 1);
        read_start(17'h03);
        read_end();
        check("err_clear", err, 0);

        // address change during a write: err, last pair commits
        ram_cs1_ = 1'b0;
        ram_cs2  = 1'b1;
        ram_addr = 17'h13;
        ram_we_  = 1'b0;
        tb_dq    = 8'h77;
        tb_dq_en = 1'b1;
        tick();
        ram_addr = 17'h14;
        tick();
        check("err_set", err, 1);
        set_idle();
        exp_wr++;
        model[4] = 8'h77;
        tick();
        repeat (3) tick();
        check("err_sticky", err, 1);
        read_start(17'h04);
        read_end();
        read_start(17'h03);
        read_end();

        // reset mid-write discards the pending write
        do_write(17'd9, 8'h00, 1);
        ram_cs1_ = 1'b0;
        ram_cs2  = 1'b1;
        ram_addr = 17'd9;
        ram_we_  = 1'b0;
        tb_dq    = 8'hFF;
        tb_dq_en = 1'b1;
        tick();
        #2;
        reset_ = 1'b0;
        #1;
        check("rst_wr_err", err, 0);
        check("rst_wr_strobe", wr_strobe, 0);
        set_idle();
        repeat (2) tick();
        reset_ = 1'b1;
        tick();
        read_start(17'd9);
        read_end();

        // reset mid-read releases the bus immediately
        read_start(17'd100);
        @(negedge clk);
        #1;
        reset_ = 1'b0;
        #1;
        check("rst_rd_valid_async", rd_valid, 0);
        check("rst_rd_wr_strobe", wr_strobe, 0);
        check("rst_rd_err", err, 0);
        set_idle();
        tick();
        reset_ = 1'b1;
        repeat (2) tick();

        check("rd_queue_drained", exp_rd_q.size(), 0);
        check("wr_all_seen", exp_wr, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
